// File: rtl/ex_operand_stage.sv
// ID/EX register with EX-side operand formation, RAW forwarding and load-use detection (EX_FWD_EN enables EX/MEM + MEM/WB forwarding).
// Latency: 1 cycle from ID capture to EX outputs; forwarded operands are combinational on the EX/MEM and MEM/WB inputs.
// Backpressure: o_stall freezes PC and IF/ID on a hazard while a bubble enters EX; a flush overrides the stall.
module ex_operand_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_id_valid,
    input  logic [XLEN-1:0]   i_id_pc,
    input  logic [REG_AW-1:0] i_id_rs1_addr,
    input  logic [REG_AW-1:0] i_id_rs2_addr,
    input  logic              i_id_rs1_use,
    input  logic              i_id_rs2_use,
    input  logic [XLEN-1:0]   i_id_rs1_data,
    input  logic [XLEN-1:0]   i_id_rs2_data,
    input  logic [XLEN-1:0]   i_id_imm,
    input  logic [3:0]        i_id_alu_op,
    input  logic [1:0]        i_id_asel,
    input  logic              i_id_bsel,
    input  logic [REG_AW-1:0] i_id_rd_addr,
    input  logic              i_id_rd_wren,
    input  logic              i_id_mem_rden,
    input  logic              i_flush,
    input  logic [REG_AW-1:0] i_exmem_rd_addr,
    input  logic              i_exmem_rd_wren,
    input  logic [XLEN-1:0]   i_exmem_data,
    input  logic [REG_AW-1:0] i_memwb_rd_addr,
    input  logic              i_memwb_rd_wren,
    input  logic [XLEN-1:0]   i_memwb_data,
    output logic              o_stall,
    output logic              o_ex_valid,
    output logic [XLEN-1:0]   o_ex_pc,
    output logic [XLEN-1:0]   o_op_a,
    output logic [XLEN-1:0]   o_op_b,
    output logic [3:0]        o_alu_op,
    output logic [XLEN-1:0]   o_rs2_fwd,
    output logic [REG_AW-1:0] o_rd_addr,
    output logic              o_rd_wren,
    output logic              o_mem_rden
);

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [XLEN-1:0]   r_imm;
    logic [3:0]        r_alu_op;
    logic [1:0]        r_asel;
    logic              r_bsel;
    logic [REG_AW-1:0] r_rd_addr;
    logic              r_rd_wren;
    logic              r_mem_rden;

    logic              w_luse;
    logic              w_bubble;
    logic              w_wb_byp1;
    logic              w_wb_byp2;
    logic [XLEN-1:0]   w_rs1_fwd;
    logic [XLEN-1:0]   w_rs2_fwd;

    // The regfile write lands in the same cycle as the ID read, so take the WB value directly at capture.
    assign w_wb_byp1 = i_memwb_rd_wren & (i_memwb_rd_addr != '0) & (i_memwb_rd_addr == i_id_rs1_addr);
    assign w_wb_byp2 = i_memwb_rd_wren & (i_memwb_rd_addr != '0) & (i_memwb_rd_addr == i_id_rs2_addr);

`ifdef EX_FWD_EN
    logic [REG_AW-1:0] r_rs1_addr;
    logic [REG_AW-1:0] r_rs2_addr;
    logic              w_ld_rd_vld;

    // Only a load in EX cannot be forwarded in time; everything else is covered by the bypass muxes.
    assign w_ld_rd_vld = r_valid & r_mem_rden & (r_rd_addr != '0);
    assign w_luse = w_ld_rd_vld & i_id_valid &
                    ((i_id_rs1_use & (i_id_rs1_addr == r_rd_addr)) |
                     (i_id_rs2_use & (i_id_rs2_addr == r_rd_addr)));

    // Source registers for forwarding: EX/MEM has the younger value and wins; x0 is never forwarded.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
        end else if (w_bubble) begin
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
        end else begin
            r_rs1_addr <= i_id_rs1_addr;
            r_rs2_addr <= i_id_rs2_addr;
        end
    end

    // Forwarding muxes on the registered source addresses.
    always_comb begin
        w_rs1_fwd = r_rs1_data;
        w_rs2_fwd = r_rs2_data;
        if (i_exmem_rd_wren && (i_exmem_rd_addr != '0) && (i_exmem_rd_addr == r_rs1_addr))
            w_rs1_fwd = i_exmem_data;
        else if (i_memwb_rd_wren && (i_memwb_rd_addr != '0) && (i_memwb_rd_addr == r_rs1_addr))
            w_rs1_fwd = i_memwb_data;
        if (i_exmem_rd_wren && (i_exmem_rd_addr != '0) && (i_exmem_rd_addr == r_rs2_addr))
            w_rs2_fwd = i_exmem_data;
        else if (i_memwb_rd_wren && (i_memwb_rd_addr != '0) && (i_memwb_rd_addr == r_rs2_addr))
            w_rs2_fwd = i_memwb_data;
    end
`else
    logic w_ex_hit1;
    logic w_ex_hit2;
    logic w_unused_exmem_data;

    // Without forwarding, any in-flight writer in ID/EX or EX/MEM blocks the read until it reaches WB.
    assign w_ex_hit1 = (r_valid & r_rd_wren & (r_rd_addr != '0) & (i_id_rs1_addr == r_rd_addr)) |
                       (i_exmem_rd_wren & (i_exmem_rd_addr != '0) & (i_id_rs1_addr == i_exmem_rd_addr));
    assign w_ex_hit2 = (r_valid & r_rd_wren & (r_rd_addr != '0) & (i_id_rs2_addr == r_rd_addr)) |
                       (i_exmem_rd_wren & (i_exmem_rd_addr != '0) & (i_id_rs2_addr == i_exmem_rd_addr));
    assign w_luse = i_id_valid & ((i_id_rs1_use & w_ex_hit1) | (i_id_rs2_use & w_ex_hit2));

    assign w_rs1_fwd = r_rs1_data;
    assign w_rs2_fwd = r_rs2_data;
    assign w_unused_exmem_data = ^i_exmem_data;
`endif

    assign w_bubble = i_flush | w_luse;
    assign o_stall  = w_luse & ~i_flush;

    // ID/EX register: flush or hazard loads a cleared bubble, otherwise capture the ID instruction.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_alu_op   <= '0;
            r_asel     <= '0;
            r_bsel     <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_wren  <= 1'b0;
            r_mem_rden <= 1'b0;
        end else if (w_bubble) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_alu_op   <= '0;
            r_asel     <= '0;
            r_bsel     <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_wren  <= 1'b0;
            r_mem_rden <= 1'b0;
        end else begin
            r_valid    <= i_id_valid;
            r_pc       <= i_id_pc;
            r_rs1_data <= w_wb_byp1 ? i_memwb_data : i_id_rs1_data;
            r_rs2_data <= w_wb_byp2 ? i_memwb_data : i_id_rs2_data;
            r_imm      <= i_id_imm;
            r_alu_op   <= i_id_alu_op;
            r_asel     <= i_id_asel;
            r_bsel     <= i_id_bsel;
            r_rd_addr  <= i_id_rd_addr;
            r_rd_wren  <= i_id_rd_wren & i_id_valid;
            r_mem_rden <= i_id_mem_rden;
        end
    end

    // Operand A select: rs1, pc, or zero (reserved encoding also gives zero).
    always_comb begin
        o_op_a = '0;
        case (r_asel)
            2'd0:    o_op_a = w_rs1_fwd;
            2'd1:    o_op_a = r_pc;
            default: o_op_a = '0;
        endcase
    end

    assign o_op_b     = r_bsel ? r_imm : w_rs2_fwd;
    assign o_rs2_fwd  = w_rs2_fwd;
    assign o_ex_valid = r_valid;
    assign o_ex_pc    = r_pc;
    assign o_alu_op   = r_alu_op;
    assign o_rd_addr  = r_rd_addr;
    assign o_rd_wren  = r_rd_wren;
    assign o_mem_rden = r_mem_rden;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed hazard scenarios plus randomized cycles against a rule-level reference model.
// Latency: outputs compared 2 time units after the falling edge, inputs driven on the falling edge.
// Backpressure: o_stall is compared each cycle against the model's hazard rule.
module tb_ex_operand_stage;

`ifdef EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        i_clk, i_rst_n;
    logic        i_id_valid;
    logic [31:0] i_id_pc;
    logic [4:0]  i_id_rs1_addr, i_id_rs2_addr;
    logic        i_id_rs1_use, i_id_rs2_use;
    logic [31:0] i_id_rs1_data, i_id_rs2_data, i_id_imm;
    logic [3:0]  i_id_alu_op;
    logic [1:0]  i_id_asel;
    logic        i_id_bsel;
    logic [4:0]  i_id_rd_addr;
    logic        i_id_rd_wren, i_id_mem_rden, i_flush;
    logic [4:0]  i_exmem_rd_addr, i_memwb_rd_addr;
    logic        i_exmem_rd_wren, i_memwb_rd_wren;
    logic [31:0] i_exmem_data, i_memwb_data;
    logic        o_stall, o_ex_valid;
    logic [31:0] o_ex_pc, o_op_a, o_op_b, o_rs2_fwd;
    logic [3:0]  o_alu_op;
    logic [4:0]  o_rd_addr;
    logic        o_rd_wren, o_mem_rden;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model of what EX currently holds
    logic        m_valid, m_wren, m_rden, m_bsel;
    logic [31:0] m_pc, m_d1, m_d2, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [3:0]  m_op;
    logic [1:0]  m_asel;

    ex_operand_stage dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_id_valid(i_id_valid), .i_id_pc(i_id_pc),
        .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
        .i_id_rs1_use(i_id_rs1_use), .i_id_rs2_use(i_id_rs2_use),
        .i_id_rs1_data(i_id_rs1_data), .i_id_rs2_data(i_id_rs2_data), .i_id_imm(i_id_imm),
        .i_id_alu_op(i_id_alu_op), .i_id_asel(i_id_asel), .i_id_bsel(i_id_bsel),
        .i_id_rd_addr(i_id_rd_addr), .i_id_rd_wren(i_id_rd_wren), .i_id_mem_rden(i_id_mem_rden),
        .i_flush(i_flush),
        .i_exmem_rd_addr(i_exmem_rd_addr), .i_exmem_rd_wren(i_exmem_rd_wren), .i_exmem_data(i_exmem_data),
        .i_memwb_rd_addr(i_memwb_rd_addr), .i_memwb_rd_wren(i_memwb_rd_wren), .i_memwb_data(i_memwb_data),
        .o_stall(o_stall), .o_ex_valid(o_ex_valid), .o_ex_pc(o_ex_pc), .o_op_a(o_op_a), .o_op_b(o_op_b),
        .o_alu_op(o_alu_op), .o_rs2_fwd(o_rs2_fwd), .o_rd_addr(o_rd_addr), .o_rd_wren(o_rd_wren),
        .o_mem_rden(o_mem_rden)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Does an ID read of register a depend on a result that is not yet obtainable?
    function automatic logic m_hazard(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (FWD) return m_valid && m_rden && (a == m_rd);
        return (m_valid && m_wren && (a == m_rd)) || (i_exmem_rd_wren && (a == i_exmem_rd_addr));
    endfunction

    function automatic logic m_luse();
        return i_id_valid && ((i_id_rs1_use && m_hazard(i_id_rs1_addr)) ||
                              (i_id_rs2_use && m_hazard(i_id_rs2_addr)));
    endfunction

    // Newest architectural value of register a as seen from EX
    function automatic logic [31:0] m_src(input logic [4:0] a, input logic [31:0] regv);
        if (FWD && a != 5'd0 && i_exmem_rd_wren && i_exmem_rd_addr == a) return i_exmem_data;
        if (FWD && a != 5'd0 && i_memwb_rd_wren && i_memwb_rd_addr == a) return i_memwb_data;
        return regv;
    endfunction

    task automatic model_clear();
        m_valid = 0; m_wren = 0; m_rden = 0; m_bsel = 0; m_pc = 0; m_d1 = 0; m_d2 = 0;
        m_imm = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_op = 0; m_asel = 0;
    endtask

    task automatic model_step();
        if (!i_rst_n || i_flush || m_luse()) begin
            model_clear();
        end else begin
            m_valid = i_id_valid;
            m_pc    = i_id_pc;
            m_rs1   = i_id_rs1_addr;
            m_rs2   = i_id_rs2_addr;
            m_d1    = (i_memwb_rd_wren && i_memwb_rd_addr != 0 && i_memwb_rd_addr == i_id_rs1_addr) ? i_memwb_data : i_id_rs1_data;
            m_d2    = (i_memwb_rd_wren && i_memwb_rd_addr != 0 && i_memwb_rd_addr == i_id_rs2_addr) ? i_memwb_data : i_id_rs2_data;
            m_imm   = i_id_imm;
            m_op    = i_id_alu_op;
            m_asel  = i_id_asel;
            m_bsel  = i_id_bsel;
            m_rd    = i_id_rd_addr;
            m_wren  = i_id_rd_wren && i_id_valid;
            m_rden  = i_id_mem_rden;
        end
    endtask

    // Advance one clock from a falling edge to the next falling edge.
    task automatic tick();
        model_step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic id_idle();
        i_id_valid = 0; i_id_pc = 0; i_id_rs1_addr = 0; i_id_rs2_addr = 0; i_id_rs1_use = 0;
        i_id_rs2_use = 0; i_id_rs1_data = 0; i_id_rs2_data = 0; i_id_imm = 0; i_id_alu_op = 0;
        i_id_asel = 0; i_id_bsel = 0; i_id_rd_addr = 0; i_id_rd_wren = 0; i_id_mem_rden = 0;
        i_flush = 0; i_exmem_rd_addr = 0; i_exmem_rd_wren = 0; i_exmem_data = 0;
        i_memwb_rd_addr = 0; i_memwb_rd_wren = 0; i_memwb_data = 0;
    endtask

    task automatic id_alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] d1, input logic [31:0] d2, input logic ld);
        i_id_valid = 1; i_id_rd_addr = rd; i_id_rd_wren = 1; i_id_mem_rden = ld;
        i_id_rs1_addr = rs1; i_id_rs1_use = 1; i_id_rs1_data = d1;
        i_id_rs2_addr = rs2; i_id_rs2_use = !ld; i_id_rs2_data = d2;
        i_id_alu_op = 0; i_id_asel = 0; i_id_bsel = ld;
    endtask

    task automatic test_reset();
        id_idle();
        i_rst_n = 0;
        model_clear();
        #2;
        n_cmp++;
        if ({o_ex_valid, o_rd_wren, o_mem_rden, o_alu_op, o_ex_pc, o_stall} !== 40'd0) begin
            n_bad++; $display("FAIL reset_ctrl got %h want 0", {o_ex_valid, o_rd_wren, o_mem_rden, o_alu_op, o_ex_pc, o_stall});
        end
        n_cmp++;
        if ({o_op_a, o_op_b, o_rs2_fwd} !== 96'd0) begin
            n_bad++; $display("FAIL reset_operands got %h want 0", {o_op_a, o_op_b, o_rs2_fwd});
        end
        @(negedge i_clk);
        tick();
        i_rst_n = 1;
        tick();
    endtask

    task automatic test_reset_midrun();
        id_idle();
        id_alu(5'd7, 5'd1, 5'd2, 32'h11, 32'h22, 1'b1);
        i_id_pc = 32'h40; i_id_alu_op = 4'd3;
        tick();
        id_idle();
        #2;
        n_cmp++;
        if ({o_ex_valid, o_rd_wren} !== 2'b11) begin
            n_bad++; $display("FAIL midrun_loaded got %b want 11", {o_ex_valid, o_rd_wren});
        end
        #1 i_rst_n = 0;
        #1;
        n_cmp++;
        if ({o_ex_valid, o_rd_wren, o_mem_rden, o_alu_op, o_ex_pc, o_stall} !== 40'd0) begin
            n_bad++; $display("FAIL midrun_async_reset got %h want 0", {o_ex_valid, o_rd_wren, o_mem_rden, o_alu_op, o_ex_pc, o_stall});
        end
        @(negedge i_clk);
        tick();
        i_rst_n = 1;
        tick();
    endtask

    task automatic test_exmem_fwd();
        id_idle(); tick();
        id_alu(5'd5, 5'd1, 5'd2, 32'h123, 32'h456, 1'b0);
        tick();
        id_idle();
        i_exmem_rd_addr = 5'd1; i_exmem_rd_wren = 1; i_exmem_data = 32'h0000_0010;
        i_memwb_rd_addr = 5'd1; i_memwb_rd_wren = 1; i_memwb_data = 32'hFFFF_FFFF;
        #2;
        n_cmp++;
        if (o_op_a !== (FWD ? 32'h10 : 32'h123)) begin
            n_bad++; $display("FAIL exmem_fwd_op_a got %h want %h", o_op_a, FWD ? 32'h10 : 32'h123);
        end
        n_cmp++;
        if ({o_alu_op, o_op_b} !== {4'd0, 32'h456}) begin
            n_bad++; $display("FAIL exmem_fwd_op_b got %h want %h", {o_alu_op, o_op_b}, {4'd0, 32'h456});
        end
        tick();
    endtask

    task automatic test_x0_guard();
        id_idle(); tick();
        id_alu(5'd9, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        i_memwb_rd_addr = 5'd0; i_memwb_rd_wren = 1; i_memwb_data = 32'hBAD0_BAD0;
        tick();
        id_idle();
        i_exmem_rd_addr = 5'd0; i_exmem_rd_wren = 1; i_exmem_data = 32'hDEAD_BEEF;
        i_memwb_rd_addr = 5'd0; i_memwb_rd_wren = 1; i_memwb_data = 32'hCAFE_F00D;
        #2;
        n_cmp++;
        if ({o_op_a, o_rs2_fwd} !== 64'd0) begin
            n_bad++; $display("FAIL x0_guard got %h want 0", {o_op_a, o_rs2_fwd});
        end
        tick();
    endtask

    task automatic test_load_use();
        id_idle(); tick();
        id_alu(5'd3, 5'd1, 5'd0, 32'h1000, 32'h0, 1'b1);
        tick();
        id_idle();
        id_alu(5'd4, 5'd3, 5'd3, 32'h0, 32'h0, 1'b0);
        #2;
        n_cmp++;
        if (o_stall !== 1'b1) begin n_bad++; $display("FAIL luse_stall got %b want 1", o_stall); end
        tick();
        i_memwb_rd_addr = 5'd3; i_memwb_rd_wren = 1; i_memwb_data = 32'h55;
        #2;
        n_cmp++;
        if ({o_ex_valid, o_stall} !== 2'b00) begin
            n_bad++; $display("FAIL luse_bubble got %b want 00", {o_ex_valid, o_stall});
        end
        tick();
        i_id_valid = 0; i_id_rs1_use = 0; i_id_rs2_use = 0;
        #2;
        n_cmp++;
        if ({o_ex_valid, o_rd_addr, o_op_a, o_op_b} !== {1'b1, 5'd4, 32'h55, 32'h55}) begin
            n_bad++; $display("FAIL luse_consumer got %h want %h", {o_ex_valid, o_rd_addr, o_op_a, o_op_b}, {1'b1, 5'd4, 32'h55, 32'h55});
        end
        tick();
    endtask

    task automatic test_flush_vs_stall();
        id_idle(); tick();
        id_alu(5'd3, 5'd1, 5'd0, 32'h0, 32'h0, 1'b1);
        tick();
        id_idle();
        id_alu(5'd4, 5'd3, 5'd3, 32'h0, 32'h0, 1'b0);
        i_flush = 1;
        #2;
        n_cmp++;
        if (o_stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall got %b want 0", o_stall); end
        tick();
        id_idle();
        #2;
        n_cmp++;
        if ({o_ex_valid, o_rd_wren, o_mem_rden} !== 3'b000) begin
            n_bad++; $display("FAIL flush_bubble got %b want 000", {o_ex_valid, o_rd_wren, o_mem_rden});
        end
    endtask

    task automatic test_imm_pc();
        id_idle(); tick();
        id_alu(5'd6, 5'd1, 5'd2, 32'h33, 32'h77, 1'b0);
        i_id_asel = 2'd1; i_id_bsel = 1; i_id_pc = 32'h0000_1000; i_id_imm = 32'hFFFF_FFFC;
        tick();
        id_idle();
        #2;
        n_cmp++;
        if ({o_op_a, o_op_b, o_rs2_fwd} !== {32'h1000, 32'hFFFF_FFFC, 32'h77}) begin
            n_bad++; $display("FAIL imm_pc got %h want %h", {o_op_a, o_op_b, o_rs2_fwd}, {32'h1000, 32'hFFFF_FFFC, 32'h77});
        end
        tick();
    endtask

    // Dependent add right behind an add: stall count depends on whether forwarding exists.
    task automatic test_dep_add();
        int  stalls;
        logic done;
        id_idle(); tick();
        id_alu(5'd5, 5'd1, 5'd2, 32'h1, 32'h2, 1'b0);
        tick();
        stalls = 0; done = 0;
        for (int k = 0; k < 6 && !done; k++) begin
            id_idle();
            id_alu(5'd6, 5'd5, 5'd0, 32'h0, 32'h0, 1'b0);
            i_id_rs2_use = 0;
            if (k == 1) begin i_exmem_rd_addr = 5'd5; i_exmem_rd_wren = 1; i_exmem_data = 32'h99; end
            if (k >= 2) begin i_memwb_rd_addr = 5'd5; i_memwb_rd_wren = 1; i_memwb_data = 32'h99; end
            #2;
            if (o_stall) stalls++;
            else done = 1;
            tick();
        end
        id_idle();
        n_cmp++;
        if (!done) begin n_bad++; $display("FAIL dep_add_timeout got stuck want capture"); end
        n_cmp++;
        if (stalls != (FWD ? 0 : 2)) begin
            n_bad++; $display("FAIL dep_add_stalls got %0d want %0d", stalls, FWD ? 0 : 2);
        end
        #2;
        n_cmp++;
        if ({o_ex_valid, o_rd_addr} !== {1'b1, 5'd6}) begin
            n_bad++; $display("FAIL dep_add_capture got %h want %h", {o_ex_valid, o_rd_addr}, {1'b1, 5'd6});
        end
        tick();
    endtask

    task automatic test_random();
        logic [140:0] exp_v, act_v;
        logic [31:0]  ea, eb, e2;
        for (int c = 0; c < 400; c++) begin
            i_id_valid = ($urandom % 4) != 0;
            i_id_pc = $urandom; i_id_imm = $urandom;
            i_id_rs1_addr = 5'($urandom % 4); i_id_rs2_addr = 5'($urandom % 4);
            i_id_rs1_use = 1'($urandom); i_id_rs2_use = 1'($urandom);
            i_id_rs1_data = $urandom; i_id_rs2_data = $urandom;
            i_id_alu_op = 4'($urandom % 10); i_id_asel = 2'($urandom); i_id_bsel = 1'($urandom);
            i_id_rd_addr = 5'($urandom % 4); i_id_rd_wren = 1'($urandom);
            i_id_mem_rden = ($urandom % 3) == 0; i_flush = ($urandom % 8) == 0;
            i_exmem_rd_addr = 5'($urandom % 4); i_exmem_rd_wren = 1'($urandom); i_exmem_data = $urandom;
            i_memwb_rd_addr = 5'($urandom % 4); i_memwb_rd_wren = 1'($urandom); i_memwb_data = $urandom;
            #2;
            e2 = m_src(m_rs2, m_d2);
            ea = (m_asel == 2'd0) ? m_src(m_rs1, m_d1) : (m_asel == 2'd1) ? m_pc : 32'd0;
            eb = m_bsel ? m_imm : e2;
            exp_v = {m_luse() && !i_flush, m_valid, m_pc, ea, eb, m_op, e2, m_rd, m_wren, m_rden};
            act_v = {o_stall, o_ex_valid, o_ex_pc, o_op_a, o_op_b, o_alu_op, o_rs2_fwd, o_rd_addr, o_rd_wren, o_mem_rden};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++; $display("FAIL random_cycle_%0d got %h want %h", c, act_v, exp_v);
            end
            tick();
        end
        id_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_exmem_fwd();
        test_x0_guard();
        test_load_use();
        test_flush_vs_stall();
        test_imm_pc();
        test_dep_add();
        test_random();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus EX-side operand formation for the pipelined RV32I core.
- Sits directly upstream of the ALU and drives its operand A, operand B and 4-bit op code.
- Captures decoded fields from ID, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and detects load-use hazards.
- On a load-use hazard it stalls IF/ID and inserts a bubble; it also inserts bubbles on branch-mispredict flush.

Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register address width

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_id_valid  in  1  ID holds a real instruction
- i_id_pc  in  XLEN  instruction PC
- i_id_rs1_addr / i_id_rs2_addr  in  REG_AW each  source registers
- i_id_rs1_use / i_id_rs2_use  in  1 each  instruction reads rs1/rs2
- i_id_rs1_data / i_id_rs2_data  in  XLEN each  register-file read data
- i_id_imm  in  XLEN  sign-extended immediate
- i_id_alu_op  in  4  ALU op code (0 add … 9 sra)
- i_id_asel  in  2  A select: 0 rs1, 1 pc, 2 zero, 3 reserved (treated as zero)
- i_id_bsel  in  1  B select: 0 rs2, 1 imm
- i_id_rd_addr  in  REG_AW  destination register
- i_id_rd_wren  in  1  writes rd
- i_id_mem_rden  in  1  instruction is a load
- i_flush  in  1  branch mispredict; kill the ID instruction
- i_exmem_rd_addr  in  REG_AW ; i_exmem_rd_wren  in  1 ; i_exmem_data  in  XLEN
- i_memwb_rd_addr  in  REG_AW ; i_memwb_rd_wren  in  1 ; i_memwb_data  in  XLEN
- o_stall  out  1  freeze PC and IF/ID this cycle
- o_ex_valid  out  1  EX holds a real instruction
- o_ex_pc  out  XLEN
- o_op_a / o_op_b  out  XLEN each  ALU operands
- o_alu_op  out  4
- o_rs2_fwd  out  XLEN  forwarded rs2, used as store data
- o_rd_addr  out  REG_AW ; o_rd_wren  out  1 ; o_mem_rden  out  1

Behaviour:
- Reset (async, i_rst_n=0): every register clears to 0. Consequences: o_ex_valid=0, o_rd_wren=0, o_mem_rden=0, o_alu_op=0, o_ex_pc=0, o_stall=0. o_op_a, o_op_b and o_rs2_fwd are 0 when the MEM/WB and EX/MEM inputs do not match.
- Reset release: synchronous use from the first rising edge with i_rst_n=1.
- Load-use detect (combinational), luse=1 when all hold:
  - ex_valid & ex_mem_rden & ex_rd≠0
  - i_id_valid
  - (rs1_use & rs1_addr==ex_rd) | (rs2_use & rs2_addr==ex_rd)
- o_stall = luse & ~i_flush.
- Register update each rising edge, in priority order:
  1. i_flush=1: load bubble (valid, rd_wren, mem_rden = 0; alu_op=0). Data fields are don't-care, but the implementation clears them to 0.
  2. luse=1: load bubble as in 1.
  3. Otherwise: capture all ID fields, with valid = i_id_valid. rd_wren is captured ANDed with i_id_valid.
- WB capture bypass: at capture, if i_memwb_rd_wren & memwb_rd≠0 & memwb_rd==rsN_addr, store i_memwb_data instead of i_id_rsN_data. This covers the regfile write occurring the same cycle as the ID read.
- Forwarding (combinational, on registered rs addresses), per source N:
  - First choice: EX/MEM when exmem_wren & exmem_rd≠0 & exmem_rd==rsN.
  - Else MEM/WB under the same condition.
  - Else the registered value.
  - EX/MEM wins over MEM/WB.
  - x0 is never forwarded: register 0 always reads the registered value, which is 0 from the regfile.
- Operand mux:
  - o_op_a = asel 0 → fwd rs1, 1 → ex_pc, 2/3 → 0.
  - o_op_b = bsel 0 → fwd rs2, 1 → imm.
  - o_rs2_fwd is always fwd rs2, regardless of bsel.
- Latency: one cycle from ID capture to EX outputs. Forwarded operands are valid in the same cycle as the EX/MEM/MEM-WB inputs.
- A stalled ID instruction is re-presented unchanged by upstream. The block holds no copy of it.
- Flush concurrent with luse: flush wins and o_stall=0.
- Back-to-back loads into the same rd: only the ID/EX copy is checked. The second consumer stalls once.

Optional Feature:
- Macro: EX_FWD_EN.
- Defined: EX/MEM and MEM/WB forwarding as above; stall only on load-use.
- Undefined:
  - No EX forwarding muxes; operands come from registered values (the WB capture bypass is kept).
  - luse is widened to any ID read matching either:
    - the ID/EX rd (ex_valid & ex_rd_wren & ≠0), or
    - the EX/MEM rd (exmem_wren & ≠0).
  - Each stall cycle inserts a bubble.
  - A dependent add behind an add stalls 2 cycles.

Test Plan:
- Reset mid-run: i_rst_n low with ex_valid=1, rd_wren=1 → all outputs 0 immediately (asynchronous), before the next edge.
- EX/MEM forward: ID/EX add x5,x1,x2 with exmem rd=x1, data 0x0000_0010 and memwb rd=x1, data 0xFFFF_FFFF → o_op_a=0x10 (EX/MEM wins), o_alu_op=0.
- x0 guard: exmem rd=x0, wren=1, data 0xDEAD_BEEF; EX reads x0 (registered 0) → o_op_a=0.
- Load-use: ID/EX lw x3; ID add x4,x3,x3 → o_stall=1 one cycle, next o_ex_valid=0. The cycle after: add captured, and with memwb rd=x3 data 0x55 → o_op_a=o_op_b=0x55.
- Flush vs stall: luse condition plus i_flush=1 → o_stall=0, next o_ex_valid=0, o_rd_wren=0.
- Immediate/PC select: asel=1, bsel=1, pc 0x0000_1000, imm 0xFFFF_FFFC → o_op_a=0x1000, o_op_b=0xFFFF_FFFC. o_rs2_fwd still equals fwd rs2.
